fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder. It owns the program counter, issues word requests to instruction memory over a valid/ready request channel, and accepts in-order responses into a small prefetch buffer. It presents `{pc, instruction}` to the decoder over a valid/ready handshake. It also handles redirects from branch/jump resolution by flushing buffered entries and discarding stale in-flight responses.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory,
// buffers in-order responses and hands {pc, instruction} to the decoder.
package rapid_pkg;
   parameter int XLEN = 32;
endpackage

module fetch_unit
   import rapid_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 4
)(
   input  logic            i_clk,
   input  logic            i_rst_n,
   output logic            o_imem_req_valid,
   input  logic            i_imem_req_ready,
   output logic [XLEN-1:0] o_imem_req_addr,
   input  logic            i_imem_rsp_valid,
   input  logic [XLEN-1:0] i_imem_rsp_data,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_instr_valid,
   input  logic            i_instr_ready,
   output logic [XLEN-1:0] o_instruction,
   output logic [XLEN-1:0] o_pc
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fifo_entry_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_pc;
   logic [CW-1:0]   outstanding, drop_cnt, drop_nxt, count;
   logic [CW:0]     credit_used;
   logic [PW-1:0]   rd_ptr, wr_ptr;
   fifo_entry_t     fifo_q [FIFO_DEPTH];
   logic            req_fire, rsp_fire, push, pop;

   // Credits cover both in-flight requests and buffered entries, so a push never overflows.
   assign credit_used      = {1'b0, outstanding} + {1'b0, count};
   assign o_imem_req_valid = (state == RUN) && (credit_used < DEPTH_W);
   assign o_imem_req_addr  = fetch_pc;
   assign req_fire         = o_imem_req_valid && i_imem_req_ready;
   assign rsp_fire         = i_imem_rsp_valid && (outstanding != '0);
   assign push             = rsp_fire && (state == RUN) && !i_redirect_valid;
   assign redirect_pc      = {i_redirect_pc[XLEN-1:2], 2'b00};

   assign o_instr_valid = (count != '0) && !i_redirect_valid;
   assign o_instruction = fifo_q[rd_ptr].instr;
   assign o_pc          = fifo_q[rd_ptr].pc;
   assign pop           = o_instr_valid && i_instr_ready;

   always_comb begin
      state_nxt = state;
      drop_nxt  = drop_cnt;
      if (i_redirect_valid) begin
         drop_nxt  = outstanding + CW'(req_fire) - CW'(rsp_fire);
         state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
      end else begin
         case (state)
            IDLE:  state_nxt = RUN;
            RUN:   state_nxt = RUN;
            DRAIN: begin
               if (rsp_fire) begin
                  drop_nxt = drop_cnt - CW'(1);
                  if (drop_nxt == '0) state_nxt = RUN;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         drop_cnt    <= drop_nxt;
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
         if (i_redirect_valid) begin
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
         end
      end
   end

   // Storage is reset too so the head reads {RESET_PC, 0} out of reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '{pc: RESET_PC, instr: '0};
      end else if (i_redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= '{pc: rsp_pc, instr: i_imem_rsp_data};
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vectors and corner sequences plus a randomized run
// scored against a queue-based model of the fetch stream.
module tb_fetch_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, req_valid, req_ready, rsp_valid, redir, instr_valid, instr_ready;
   logic [31:0] req_addr, rsp_data, redir_pc, instruction, pc;
   logic        req_valid2, rsp_valid2, instr_valid2;
   logic [31:0] req_addr2, rsp_data2, instruction2, pc2;

   fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
      .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
      .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
      .o_instr_valid(instr_valid), .i_instr_ready(instr_ready),
      .o_instruction(instruction), .o_pc(pc));

   fetch_unit #(.RESET_PC(RPC2), .FIFO_DEPTH(DEPTH)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_imem_req_valid(req_valid2), .i_imem_req_ready(1'b1), .o_imem_req_addr(req_addr2),
      .i_imem_rsp_valid(rsp_valid2), .i_imem_rsp_data(rsp_data2),
      .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
      .o_instr_valid(instr_valid2), .i_instr_ready(1'b1),
      .o_instruction(instruction2), .o_pc(pc2));

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
   typedef struct {
      bit rdy; bit dec; bit e_rv; logic [31:0] e_ra; bit e_iv; logic [31:0] e_pc; logic [31:0] e_ins;
   } vec_t;

   int n_chk = 0, n_err = 0, cyc = 0;
   int unsigned rdy_pct = 100, dec_pct = 100, redir_pm = 0, lat_lo = 1, lat_hi = 1;
   bit data_is_addr = 1'b1, force_rsp = 1'b0, release_now = 1'b0, redir_now = 1'b0, use_tbl = 1'b0;
   logic [31:0] redir_tgt = '0;
   vec_t cur;
   mreq_t mq[$];
   logic [31:0] rq_addr[$], dlv_pc[$], dlv_ins[$];
   int rq_cyc[$];
   bit p2_valid = 1'b0;
   logic [31:0] p2_addr = '0;
   int d2_n = 0;
   logic [31:0] d2_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

   // reference model of the fetch stream
   bit m_idle;
   logic [31:0] m_fpc, m_rpc;
   int m_infl, m_stale;
   ent_t m_q[$];

   function automatic logic [31:0] mem(input logic [31:0] a);
      return data_is_addr ? a : ((a ^ 32'h5A5A_0000) + 32'h13);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_idle = 1'b1; m_fpc = RPC; m_rpc = RPC; m_infl = 0; m_stale = 0; m_q.delete();
   endtask

   task automatic step();
      bit exp_rv, exp_iv, req_f, rsp_f, pop, dut_rf, nv2;
      logic [31:0] dut_ra, na2;
      @(negedge clk);
      if (release_now) begin rst_n = 1'b1; release_now = 1'b0; end
      req_ready   = $urandom_range(99) < rdy_pct;
      instr_ready = $urandom_range(99) < dec_pct;
      rsp_valid   = (mq.size() > 0) && (force_rsp || mq[0].due <= cyc);
      rsp_data    = rsp_valid ? mem(mq[0].addr) : 32'h0;
      redir       = redir_now || ($urandom_range(999) < redir_pm);
      redir_pc    = redir_now ? redir_tgt :
                    ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      redir_now   = 1'b0;
      rsp_valid2  = p2_valid;
      rsp_data2   = mem(p2_addr);
      #1;
      exp_rv = !m_idle && m_stale == 0 && (m_infl + m_q.size() < DEPTH);
      exp_iv = m_q.size() != 0 && !redir;
      if (!rst_n) begin
         chk("rst_req_valid", req_valid, 0);
         chk("rst_instr_valid", instr_valid, 0);
         chk("rst_instruction", instruction, 0);
         chk("rst_pc", pc, RPC);
      end else begin
         chk("req_valid", req_valid, exp_rv);
         if (exp_rv) chk("req_addr", req_addr, m_fpc);
         chk("instr_valid", instr_valid, exp_iv);
         if (exp_iv) begin
            chk("pc", pc, m_q[0].pc);
            chk("instr", instruction, m_q[0].ins);
         end
         if (use_tbl) begin
            chk("tbl_req_valid", req_valid, cur.e_rv);
            if (cur.e_rv) chk("tbl_req_addr", req_addr, cur.e_ra);
            chk("tbl_instr_valid", instr_valid, cur.e_iv);
            if (cur.e_iv) begin
               chk("tbl_pc", pc, cur.e_pc);
               chk("tbl_instr", instruction, cur.e_ins);
            end
         end
         if (instr_valid && instr_ready) begin dlv_pc.push_back(pc); dlv_ins.push_back(instruction); end
         if (instr_valid2 && d2_n < 3) begin
            chk("wrap_pc", pc2, d2_exp[d2_n]);
            chk("wrap_instr", instruction2, mem(d2_exp[d2_n]));
            d2_n++;
         end
      end
      dut_rf = rst_n && req_valid && req_ready;
      dut_ra = req_addr;
      nv2 = rst_n && req_valid2;
      na2 = req_addr2;
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         req_f = exp_rv && req_ready;
         rsp_f = rsp_valid && m_infl > 0;
         pop   = exp_iv && instr_ready;
         if (redir) begin
            m_q.delete();
            m_stale = m_infl + int'(req_f) - int'(rsp_f);
            m_fpc = {redir_pc[31:2], 2'b00};
            m_rpc = m_fpc;
         end else begin
            if (pop) void'(m_q.pop_front());
            if (rsp_f) begin
               if (m_stale > 0) m_stale--;
               else begin m_q.push_back('{pc: m_rpc, ins: mem(m_rpc)}); m_rpc += 32'd4; end
            end
            if (req_f) m_fpc += 32'd4;
         end
         m_infl += int'(req_f) - int'(rsp_f);
         m_idle = 1'b0;
      end
      if (rsp_valid) void'(mq.pop_front());
      if (dut_rf) begin
         mq.push_back('{addr: dut_ra, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
         rq_addr.push_back(dut_ra);
         rq_cyc.push_back(cyc);
      end
      p2_valid = nv2;
      p2_addr  = na2;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      mq.delete(); rq_addr.delete(); rq_cyc.delete(); dlv_pc.delete(); dlv_ins.delete();
      step(); step();
      release_now = 1'b1;
   endtask

   vec_t tbl [8];
   int rc;

   initial begin
      rst_n = 1'b0; req_ready = 0; rsp_valid = 0; rsp_data = 0; redir = 0; redir_pc = 0;
      instr_ready = 0; rsp_valid2 = 0; rsp_data2 = 0;
      tbl[0] = '{1, 1, 0, 32'h00, 0, 32'h00, 32'h00};
      tbl[1] = '{1, 1, 1, 32'h00, 0, 32'h00, 32'h00};
      tbl[2] = '{1, 1, 1, 32'h04, 0, 32'h00, 32'h00};
      tbl[3] = '{1, 1, 1, 32'h08, 1, 32'h00, 32'h00};
      tbl[4] = '{1, 1, 1, 32'h0C, 1, 32'h04, 32'h04};
      tbl[5] = '{1, 1, 1, 32'h10, 1, 32'h08, 32'h08};
      tbl[6] = '{1, 1, 1, 32'h14, 1, 32'h0C, 32'h0C};
      tbl[7] = '{1, 1, 1, 32'h18, 1, 32'h10, 32'h10};

      // streaming from reset, data = address, 1-cycle memory
      data_is_addr = 1'b1;
      do_reset();
      use_tbl = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cur = tbl[i];
         rdy_pct = cur.rdy ? 100 : 0;
         dec_pct = cur.dec ? 100 : 0;
         step();
      end
      use_tbl = 1'b0;
      chk("wrap_seen", d2_n, 3);

      // decoder stalled: credits cap requests at DEPTH
      data_is_addr = 1'b0;
      do_reset();
      rdy_pct = 100; dec_pct = 0; lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 12; i++) step();
      chk("stall_req_count", rq_addr.size(), 4);
      chk("stall_head_pc", pc, 32'h0);
      dec_pct = 100;
      for (int i = 0; i < 8; i++) step();
      for (int i = 0; i < 4; i++) chk("stall_drain_pc", dlv_pc.size() > i ? dlv_pc[i] : 32'hDEAD_BEEF, 32'(4 * i));
      chk("stall_resume_addr", rq_addr.size() > 4 ? rq_addr[4] : 32'hDEAD_BEEF, 32'h10);

      // redirect with 2 outstanding and 1 arriving in the same cycle
      do_reset();
      lat_lo = 3; lat_hi = 3; rdy_pct = 100; dec_pct = 100;
      for (int i = 0; i < 4; i++) step();
      rdy_pct = 0; redir_now = 1'b1; redir_tgt = 32'h100; rc = cyc;
      step();
      rdy_pct = 100;
      for (int i = 0; i < 10; i++) step();
      chk("redir_req_addr", rq_addr.size() > 3 ? rq_addr[3] : 32'hDEAD_BEEF, 32'h100);
      chk("redir_req_cycle", rq_cyc.size() > 3 ? rq_cyc[3] : -1, rc + 3);
      chk("redir_first_pc", dlv_pc.size() > 0 ? dlv_pc[0] : 32'hDEAD_BEEF, 32'h100);
      chk("redir_first_ins", dlv_ins.size() > 0 ? dlv_ins[0] : 32'hDEAD_BEEF, mem(32'h100));

      // redirect with nothing outstanding, then a second redirect while draining
      do_reset();
      rdy_pct = 0;
      for (int i = 0; i < 3; i++) step();
      redir_now = 1'b1; redir_tgt = 32'h203; rc = cyc;
      step();
      rdy_pct = 100;
      step(); step();
      chk("idle_redir_addr", rq_addr.size() > 0 ? rq_addr[0] : 32'hDEAD_BEEF, 32'h200);
      chk("idle_redir_cycle", rq_cyc.size() > 0 ? rq_cyc[0] : -1, rc + 1);
      rdy_pct = 0; redir_now = 1'b1; redir_tgt = 32'h400;
      step();
      rdy_pct = 100; redir_now = 1'b1; redir_tgt = 32'h300;
      step();
      for (int i = 0; i < 10; i++) step();
      chk("drain_redir_req", rq_addr.size() > 2 ? rq_addr[2] : 32'hDEAD_BEEF, 32'h300);
      chk("drain_redir_pc", dlv_pc.size() > 0 ? dlv_pc[0] : 32'hDEAD_BEEF, 32'h300);
      chk("drain_redir_ins", dlv_ins.size() > 0 ? dlv_ins[0] : 32'hDEAD_BEEF, mem(32'h300));

      // asynchronous reset mid-stream with 3 outstanding
      do_reset();
      lat_lo = 4; lat_hi = 4; rdy_pct = 100; dec_pct = 0;
      for (int i = 0; i < 20 && m_infl < 3; i++) step();
      chk("arst_setup_infl", m_infl, 3);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_req_valid", req_valid, 0);
      chk("arst_instr_valid", instr_valid, 0);
      chk("arst_instruction", instruction, 0);
      chk("arst_pc", pc, RPC);
      model_reset();
      rq_addr.delete(); rq_cyc.delete();
      force_rsp = 1'b1;
      for (int i = 0; i < 10 && mq.size() > 1; i++) step();
      release_now = 1'b1;
      step();
      force_rsp = 1'b0; dec_pct = 100; lat_lo = 1; lat_hi = 2;
      for (int i = 0; i < 10; i++) step();
      chk("arst_restart_addr", rq_addr.size() > 0 ? rq_addr[0] : 32'hDEAD_BEEF, RPC);

      // randomized traffic with redirects against the model
      do_reset();
      rdy_pct = 70; dec_pct = 70; redir_pm = 30; lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 3000; i++) step();
      redir_pm = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
